// File: rtl/sreg_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// sreg_deserializer_pkg
// Shared definitions for the serial shift-register path (rotator and
// deserializer): bit-order encodings, FSM state type and count-width helper.
// ---------------------------------------------------------------------------
package sreg_deserializer_pkg;

   // Bit order, sampled with start
   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } sreg_state_t;

   // Width of a counter that indexes 0 .. n-1 (never narrower than 1 bit)
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage : sreg_deserializer_pkg

// File: rtl/sreg_hold_buf.sv
// ---------------------------------------------------------------------------
// sreg_hold_buf
// One-entry valid/ready holding register for serial receivers.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   load_valid         : a completed word is presented this cycle
//   load_data [N]      : the completed word
//   out_ready          : consumer accepts Q this cycle
//   ovr_clr            : clears the sticky overrun flag
//   Q [N], q_valid     : held word and its valid flag
//   overrun            : sticky, a completed word was dropped
// A word loads when the buffer is empty or is being drained in the same
// cycle; otherwise it is dropped and overrun is raised.
// ---------------------------------------------------------------------------
module sreg_hold_buf #(
   parameter int N = 8
) (
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   input  logic         load_valid,
   input  logic [N-1:0] load_data,
   input  logic         out_ready,
   input  logic         ovr_clr,
   output logic [N-1:0] Q,
   output logic         q_valid,
   output logic         overrun
);

   logic xfer;
   logic can_load;
   logic ovr_event;

   always_comb begin
      xfer      = q_valid & out_ready;
      can_load  = ~q_valid | out_ready;
      ovr_event = load_valid & ~can_load;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         Q       <= '0;
         q_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (load_valid && can_load) begin
            Q       <= load_data;
            q_valid <= 1'b1;
         end else if (xfer) begin
            q_valid <= 1'b0;
         end

         // set has priority over clear
         if (ovr_event)
            overrun <= 1'b1;
         else if (ovr_clr)
            overrun <= 1'b0;
      end
   end

endmodule : sreg_hold_buf

// File: rtl/sreg_deserializer.sv
// ---------------------------------------------------------------------------
// sreg_deserializer
// Serial-in, parallel-out shift register with per-frame bit order.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   start, dir         : frame start / resync; bit order (0 LSB-first)
//   din, din_valid     : serial bit and its qualifier (gaps allowed)
//   out_ready          : consumer accepts Q this cycle
//   ovr_clr            : clears overrun
//   Q [N], q_valid     : completed word handshake
//   busy               : frame in progress
//   overrun            : sticky, a completed word was dropped
// ---------------------------------------------------------------------------
module sreg_deserializer
   import sreg_deserializer_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   input  logic         start,
   input  logic         dir,
   input  logic         din,
   input  logic         din_valid,
   input  logic         out_ready,
   input  logic         ovr_clr,
   output logic [N-1:0] Q,
   output logic         q_valid,
   output logic         busy,
   output logic         overrun
);

   localparam int            CW       = cnt_width(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   sreg_state_t   state;
   logic [N-1:0]  sr;
   logic [N-1:0]  sr_next;
   logic [CW-1:0] cnt;
   logic          dir_r;
   logic          frame_done;

   // The word handed to the holding buffer is the shift result including
   // the final bit, so it loads on the same edge that accepts that bit.
   always_comb begin
      sr_next = (dir_r == DIR_MSB_FIRST) ? {sr[N-2:0], din} : {din, sr[N-1:1]};
      frame_done = (state == ST_SHIFT) && din_valid && !start && (cnt == CNT_LAST);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= ST_IDLE;
         sr    <= '0;
         cnt   <= '0;
         dir_r <= DIR_LSB_FIRST;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_SHIFT;
                  dir_r <= dir;
                  cnt   <= '0;
                  sr    <= '0;
               end
            end
            ST_SHIFT: begin
               if (start) begin
                  // resync: discard partial frame, relatch order
                  dir_r <= dir;
                  cnt   <= '0;
                  sr    <= '0;
               end else if (din_valid) begin
                  sr <= sr_next;
                  if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     state <= ST_IDLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state == ST_SHIFT);

   sreg_hold_buf #(
      .N(N)
   ) u_hold_buf (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .load_valid(frame_done),
      .load_data (sr_next),
      .out_ready (out_ready),
      .ovr_clr   (ovr_clr),
      .Q         (Q),
      .q_valid   (q_valid),
      .overrun   (overrun)
   );

endmodule : sreg_deserializer

// File: tb/tb_sreg_deserializer.sv
// ---------------------------------------------------------------------------
// tb_sreg_deserializer
// Directed bench for sreg_deserializer (N=8). Inputs are driven and outputs
// sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_sreg_deserializer;

   localparam int N = 8;

   logic         sys_clk;
   logic         sys_rst_n;
   logic         start;
   logic         dir;
   logic         din;
   logic         din_valid;
   logic         out_ready;
   logic         ovr_clr;
   logic [N-1:0] Q;
   logic         q_valid;
   logic         busy;
   logic         overrun;

   int unsigned  n_checks;
   int unsigned  n_errors;

   sreg_deserializer #(
      .N(N)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .start     (start),
      .dir       (dir),
      .din       (din),
      .din_valid (din_valid),
      .out_ready (out_ready),
      .ovr_clr   (ovr_clr),
      .Q         (Q),
      .q_valid   (q_valid),
      .busy      (busy),
      .overrun   (overrun)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   // bits[7] is the first bit on the wire; out_ready is rdy_mid for all
   // bits except the last, which uses rdy_last.
   task automatic send_frame(input logic d, input logic [7:0] bits,
                             input logic rdy_mid, input logic rdy_last);
      start = 1'b1;
      dir   = d;
      step();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         din       = bits[7-i];
         din_valid = 1'b1;
         out_ready = (i == N-1) ? rdy_last : rdy_mid;
         step();
      end
      din_valid = 1'b0;
      din       = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      sys_rst_n = 1'b0;
      start     = 1'b0;
      dir       = 1'b0;
      din       = 1'b0;
      din_valid = 1'b0;
      out_ready = 1'b0;
      ovr_clr   = 1'b0;
      step();
      step();
      check("rst_Q", 32'(Q), 32'h0);
      check("rst_qv", 32'(q_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_ovr", 32'(overrun), 32'h0);
      sys_rst_n = 1'b1;
      step();

      // din_valid in IDLE is ignored
      din = 1'b1; din_valid = 1'b1;
      step(); step();
      din_valid = 1'b0; din = 1'b0;
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_qv", 32'(q_valid), 32'h0);

      // LSB-first, ready consumer
      start = 1'b1; dir = 1'b0;
      step();
      start = 1'b0;
      check("lsb_busy_start", 32'(busy), 32'h1);
      check("lsb_qv_start", 32'(q_valid), 32'h0);
      for (int i = 0; i < N; i++) begin
         logic [7:0] pat;
         pat = 8'b1011_0010;
         din = pat[7-i]; din_valid = 1'b1; out_ready = 1'b1;
         step();
         if (i < N-1) check("lsb_qv_early", 32'(q_valid), 32'h0);
      end
      din_valid = 1'b0;
      check("lsb_Q", 32'(Q), 32'h4D);
      check("lsb_qv", 32'(q_valid), 32'h1);
      check("lsb_busy_done", 32'(busy), 32'h0);
      step();
      check("lsb_qv_drop", 32'(q_valid), 32'h0);
      check("lsb_Q_keep", 32'(Q), 32'h4D);

      // MSB-first with a 2-cycle gap between bits 3 and 4
      out_ready = 1'b0;
      start = 1'b1; dir = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         logic [7:0] pat;
         pat = 8'b1011_0010;
         if (i == 3) begin
            din = 1'b1; din_valid = 1'b0;
            step(); step();
            check("gap_busy", 32'(busy), 32'h1);
         end
         din = pat[7-i]; din_valid = 1'b1;
         step();
      end
      din_valid = 1'b0;
      check("msb_Q", 32'(Q), 32'hB2);
      check("msb_qv", 32'(q_valid), 32'h1);
      out_ready = 1'b1;
      step();
      check("msb_qv_drop", 32'(q_valid), 32'h0);

      // Back-pressure: A held, B dropped
      send_frame(1'b0, 8'b1011_0010, 1'b0, 1'b0);
      check("bp_A_Q", 32'(Q), 32'h4D);
      check("bp_A_ovr", 32'(overrun), 32'h0);
      send_frame(1'b0, 8'hFF, 1'b0, 1'b0);
      check("bp_B_Q", 32'(Q), 32'h4D);
      check("bp_B_qv", 32'(q_valid), 32'h1);
      check("bp_B_ovr", 32'(overrun), 32'h1);
      step();
      check("bp_ovr_sticky", 32'(overrun), 32'h1);
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      check("bp_ovr_clr", 32'(overrun), 32'h0);
      check("bp_qv_hold", 32'(q_valid), 32'h1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_qv_drop", 32'(q_valid), 32'h0);
      check("bp_Q_keep", 32'(Q), 32'h4D);

      // Drain and load in the same cycle
      send_frame(1'b0, 8'b1011_0010, 1'b0, 1'b0);
      check("dl_A_qv", 32'(q_valid), 32'h1);
      send_frame(1'b0, 8'h00, 1'b0, 1'b1);
      out_ready = 1'b0;
      check("dl_Q", 32'(Q), 32'h00);
      check("dl_qv", 32'(q_valid), 32'h1);
      check("dl_ovr", 32'(overrun), 32'h0);
      out_ready = 1'b1;
      step();
      check("dl_qv_drop", 32'(q_valid), 32'h0);

      // Resync: 3 ones, restart MSB-first
      start = 1'b1; dir = 1'b0;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         din = 1'b1; din_valid = 1'b1;
         step();
      end
      din_valid = 1'b0;
      send_frame(1'b1, 8'b0000_1111, 1'b1, 1'b1);
      check("rs_Q", 32'(Q), 32'h0F);
      check("rs_qv", 32'(q_valid), 32'h1);
      check("rs_ovr", 32'(overrun), 32'h0);
      step();

      // start coincides with the last bit: word discarded, new frame begins
      start = 1'b1; dir = 1'b0;
      step();
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         din = 1'b1; din_valid = 1'b1;
         if (i == N-1) start = 1'b1;
         step();
      end
      start = 1'b0; din_valid = 1'b0;
      check("sw_qv", 32'(q_valid), 32'h0);
      check("sw_busy", 32'(busy), 32'h1);
      check("sw_Q", 32'(Q), 32'h0F);

      // Reset mid-frame with a word pending
      send_frame(1'b0, 8'b1011_0010, 1'b0, 1'b0);
      check("rm_qv_pre", 32'(q_valid), 32'h1);
      start = 1'b1; dir = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         din = 1'b1; din_valid = 1'b1;
         step();
      end
      din_valid = 1'b0;
      check("rm_busy_pre", 32'(busy), 32'h1);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("rm_Q", 32'(Q), 32'h0);
      check("rm_qv", 32'(q_valid), 32'h0);
      check("rm_busy", 32'(busy), 32'h0);
      check("rm_ovr", 32'(overrun), 32'h0);
      step();
      sys_rst_n = 1'b1;
      step();
      send_frame(1'b0, 8'b1011_0010, 1'b1, 1'b1);
      check("rm_post_Q", 32'(Q), 32'h4D);
      check("rm_post_qv", 32'(q_valid), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Safety net against a stalled run
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule : tb_sreg_deserializer
